// File: rtl/rip_gshare_predictor.sv
// rip_gshare_predictor
//   Branch direction predictor built on a Pattern History Table (PHT) of
//   saturating counters. MODE=1 indexes the table with PC bits XOR global
//   history (gshare), and MODE=0 indexes it with PC bits only (bimodal).
//   After reset the table is swept to weakly-untaken, one entry per cycle.
//   Prediction and update requests are accepted only once that sweep is done.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   pc, req              fetch PC and prediction request
//   ready                table initialised, req/upd accepted
//   pred_valid           prediction outputs valid (one cycle after accepted req)
//   pred, pred_counter   predicted direction (counter MSB) and counter read
//   pred_index           PHT index used, handed back later as upd_index
//   upd_valid            resolved-branch update strobe
//   upd_index            index to update
//   upd_counter          counter value to update from
//   upd_taken            actual branch outcome
//   ghr                  global history register
module rip_gshare_predictor #(
  parameter int unsigned INDEX_WIDTH   = 10,
  parameter int unsigned PC_LSB        = 2,
  parameter int unsigned COUNTER_WIDTH = 2,
  parameter int unsigned HISTORY_WIDTH = 10,
  parameter int unsigned MODE          = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              pc,
  input  logic                     req,
  output logic                     ready,
  output logic                     pred_valid,
  output logic                     pred,
  output logic [COUNTER_WIDTH-1:0] pred_counter,
  output logic [INDEX_WIDTH-1:0]   pred_index,
  input  logic                     upd_valid,
  input  logic [INDEX_WIDTH-1:0]   upd_index,
  input  logic [COUNTER_WIDTH-1:0] upd_counter,
  input  logic                     upd_taken,
  output logic [HISTORY_WIDTH-1:0] ghr
);

  localparam int unsigned ENTRIES = 1 << INDEX_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0] WEAK_NT =
    COUNTER_WIDTH'((1 << (COUNTER_WIDTH - 1)) - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                   state_q, state_d;
  logic [INDEX_WIDTH-1:0]   sweep_q, sweep_d;
  logic [HISTORY_WIDTH-1:0] ghr_q, ghr_d;
  logic                     pred_valid_q, pred_valid_d;
  logic [COUNTER_WIDTH-1:0] pred_counter_q, pred_counter_d;
  logic [INDEX_WIDTH-1:0]   pred_index_q, pred_index_d;

  logic [COUNTER_WIDTH-1:0] pht_q [ENTRIES];

  logic                     run;
  logic                     req_fire;
  logic                     upd_fire;
  logic [INDEX_WIDTH-1:0]   base_idx;
  logic [INDEX_WIDTH-1:0]   lookup_idx;
  logic [COUNTER_WIDTH-1:0] upd_new;
  logic                     pht_we;
  logic [INDEX_WIDTH-1:0]   pht_waddr;
  logic [COUNTER_WIDTH-1:0] pht_wdata;
  logic                     unused_pc_bits;

  // Only a slice of pc is used for indexing.
  assign unused_pc_bits = ^pc;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Next-state logic: sweep every entry once, then run.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == '1) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sweep_d = '0;
      end
      default: begin
        state_d = ST_INIT;
        sweep_d = '0;
      end
    endcase
  end

  // FSM outputs.
  always_comb begin
    run = 1'b0;
    if (state_q == ST_RUN) begin
      run = 1'b1;
    end
  end

  assign ready    = run;
  assign req_fire = req & run;
  assign upd_fire = upd_valid & run;

  assign base_idx = pc[PC_LSB +: INDEX_WIDTH];

  always_comb begin
    lookup_idx = base_idx;
    if (MODE == 1) begin
      lookup_idx = base_idx ^ INDEX_WIDTH'(ghr_q);
    end
  end

  // Saturating increment/decrement of the returned counter.
  always_comb begin
    upd_new = upd_counter;
    if (upd_taken) begin
      if (upd_counter != '1) begin
        upd_new = upd_counter + 1'b1;
      end
    end else begin
      if (upd_counter != '0) begin
        upd_new = upd_counter - 1'b1;
      end
    end
  end

  // The sweep owns the single write port during INIT.
  always_comb begin
    pht_we    = 1'b0;
    pht_waddr = upd_index;
    pht_wdata = upd_new;
    if (state_q == ST_INIT) begin
      pht_we    = 1'b1;
      pht_waddr = sweep_q;
      pht_wdata = WEAK_NT;
    end else if (upd_fire) begin
      pht_we = 1'b1;
    end
  end

  // Table storage is not reset; the post-reset sweep initialises it.
  always_ff @(posedge clk) begin
    if (pht_we) begin
      pht_q[pht_waddr] <= pht_wdata;
    end
  end

  // Read with write-first bypass on a same-cycle update to the same entry.
  // The lookup uses the pre-edge history even when an update shifts it.
  always_comb begin
    pred_valid_d   = req_fire;
    pred_counter_d = pred_counter_q;
    pred_index_d   = pred_index_q;
    ghr_d          = ghr_q;
    if (req_fire) begin
      pred_index_d = lookup_idx;
      if (upd_fire && (upd_index == lookup_idx)) begin
        pred_counter_d = upd_new;
      end else begin
        pred_counter_d = pht_q[lookup_idx];
      end
    end
    if (upd_fire) begin
      ghr_d = HISTORY_WIDTH'({ghr_q, upd_taken});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q          <= '0;
      pred_valid_q   <= 1'b0;
      pred_counter_q <= '0;
      pred_index_q   <= '0;
    end else begin
      ghr_q          <= ghr_d;
      pred_valid_q   <= pred_valid_d;
      pred_counter_q <= pred_counter_d;
      pred_index_q   <= pred_index_d;
    end
  end

  assign ghr          = ghr_q;
  assign pred_valid   = pred_valid_q;
  assign pred_counter = pred_counter_q;
  assign pred         = pred_counter_q[COUNTER_WIDTH-1];
  assign pred_index   = pred_index_q;

endmodule
